// File: rtl/dual_port_mem_ctrl.sv
// Two-port word memory with registered reads, address echo and a wipe sequencer.
// Read latency 1 clock; ports are locked out (requests dropped) while a wipe runs.
module dual_port_mem_ctrl #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 4,
    parameter logic [DATA_W-1:0]  WIPE_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wipe,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr_in,
    input  logic [DATA_W-1:0] a_din,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr_in,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] a_dout,
    output logic [DATA_W-1:0] b_dout,
    output logic              a_valid,
    output logic              b_valid,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              busy,
    output logic              wipe_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE = 1'b0, WIPE = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic                done_nxt;
    logic                a_acc, b_acc;
    logic                wipe_wr;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wipe_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wipe_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        a_acc     = 1'b0;
        b_acc     = 1'b0;
        wipe_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (wipe) begin
                    state_nxt = WIPE;
                    cnt_nxt   = '0;
                end else begin
                    a_acc = a_en;
                    b_acc = b_en;
                end
            end
            WIPE: begin
                wipe_wr = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WIPE);

    // Port B writes first so a same-address port A write overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIPE_VAL;
            end
            a_dout  <= '0;
            b_dout  <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            a_addr  <= '0;
            b_addr  <= '0;
        end else begin
            a_valid <= a_acc && !a_we;
            b_valid <= b_acc && !b_we;
            if (wipe_wr) begin
                mem[cnt] <= WIPE_VAL;
            end
            if (b_acc) begin
                b_addr <= b_addr_in;
                if (b_we) begin
                    mem[b_addr_in] <= b_din;
                end else begin
                    b_dout <= mem[b_addr_in];
                end
            end
            if (a_acc) begin
                a_addr <= a_addr_in;
                if (a_we) begin
                    mem[a_addr_in] <= a_din;
                end else begin
                    a_dout <= mem[a_addr_in];
                end
            end
        end
    end

endmodule

// File: doc/dual_port_mem_ctrl.md
Name: dual_port_mem_ctrl

Overview:
- Parametrised two-port word memory with a registered read path, per-port valid flags, address echo and a hardware wipe sequencer.
- Shared array of DEPTH = 2**ADDR_W words of DATA_W bits. Ports A and B may each read or write any address every cycle.
- Sits between the datapath operand fetch and the operand store; successor to the fixed 8-bit/16-entry operand memory interface.

Parameters:
- DATA_W, 8: word width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W.
- WIPE_VAL, 0: DATA_W-bit value written to every word by a wipe.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- wipe  in  1  wipe request, sampled each cycle.
- a_en  in  1  port A request.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr_in  in  ADDR_W  port A address.
- a_din  in  DATA_W  port A write data.
- b_en, b_we, b_addr_in, b_din: as for port A, for port B.
- a_dout  out  DATA_W  port A read data (registered).
- b_dout  out  DATA_W  port B read data (registered).
- a_valid  out  1  a_dout valid; 1-cycle pulse per accepted read.
- b_valid  out  1  same, for port B.
- a_addr  out  ADDR_W  address of the last accepted port A request.
- b_addr  out  ADDR_W  address of the last accepted port B request.
- busy  out  1  high while the wipe is in progress.
- wipe_done  out  1  1-cycle pulse when the wipe completes.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - All outputs go to 0, FSM goes to IDLE, wipe counter goes to 0.
  - Every memory word is set to WIPE_VAL in the same edge.
  - Reset asserted mid-wipe aborts the wipe; no wipe_done pulse is produced.
- FSM states:
  - IDLE: requests are accepted.
  - WIPE: ports are locked out.
- IDLE transitions:
  - wipe=1 → WIPE next cycle; counter loads 0.
  - Port requests in the cycle wipe=1 is sampled are dropped: no memory change, no valid, no address echo update.
- WIPE behaviour:
  - Each cycle, mem[counter] is written with WIPE_VAL and the counter increments.
  - busy = 1 for exactly DEPTH cycles, starting the cycle after wipe is sampled.
  - After counter = DEPTH-1 is written, the FSM returns to IDLE and wipe_done pulses high for that one cycle (first IDLE cycle). busy is 0 in that cycle.
  - a_en/b_en are ignored during WIPE: valids stay 0 and dout/addr hold their values.
  - wipe=1 during WIPE is ignored; there is no restart.
- Accepted request (IDLE, wipe=0, x_en=1):
  - x_addr is updated to x_addr_in on the next edge.
- Read (x_we=0):
  - x_dout = mem[x_addr_in] on the next edge; x_valid = 1 for that one cycle.
  - Read latency is 1 clock.
  - x_dout holds its value when there is no new read.
- Write (x_we=1):
  - mem[x_addr_in] = x_din on the next edge.
  - x_valid = 0; x_dout is unchanged.
- Same-cycle collisions:
  - Both ports write the same address: port A data wins.
  - One port reads an address the other port writes in the same cycle: the reader gets the old (pre-write) data.
  - Both ports read the same address: both get the same data.
- Addresses cover the full ADDR_W range; there is no out-of-range case.
- x_en=0: no state change for that port, and x_valid = 0.

Test Plan (DATA_W=8, ADDR_W=4):
1. Reset, then A writes 0x5A @3 while B writes 0xC3 @9; next cycle A reads @9 and B reads @3 → one cycle later a_dout=0xC3, b_dout=0x5A, a_valid=b_valid=1 for exactly one cycle, a_addr=9, b_addr=3.
2. Same-cycle write collision: A writes 0x11 @7 and B writes 0x22 @7; then A reads @7 → 0x11.
3. Read-during-write: mem[4]=0xAA; in the same cycle A writes 0xBB @4 and B reads @4 → b_dout=0xAA; next B read @4 → 0xBB.
4. Wipe:
   - Fill all 16 words with 0xFF, pulse wipe with a_en=1 (read @0) in the same cycle → no a_valid.
   - busy is high for 16 cycles; wipe_done pulses on cycle 17.
   - Reads issued during busy produce no valid.
   - Afterwards, reads of @0 and @15 → 0x00.
5. Reset mid-wipe: start a wipe, assert reset at busy cycle 5 → the next cycle busy=0, all outputs 0, no wipe_done; a read @12 → 0x00 with a_valid=1.
6. Idle hold: after a read of 0x5A, hold a_en=0 for 3 cycles → a_dout stays 0x5A and a_valid stays 0.
